// File: rtl/if_id_fetch_queue.sv
// DEPTH-entry IF/ID instruction queue with valid/ready on both sides, one-cycle flush and NOP-on-empty.
// Define IF_ID_BYPASS_EN to let an offered entry reach ID combinationally while the queue is empty.
module if_id_fetch_queue #(
    parameter int          XLEN      = 32,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       if_valid_i,
    input  logic [XLEN-1:0]            if_pc_i,
    input  logic [31:0]                if_instr_i,
    output logic                       if_ready_o,
    input  logic                       flush_i,
    output logic                       id_valid_o,
    output logic [XLEN-1:0]            id_pc_o,
    output logic [31:0]                id_instr_o,
    input  logic                       id_ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic full, empty, bypass_active;
    logic push, pop, push_store, pop_store;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

`ifdef IF_ID_BYPASS_EN
    assign bypass_active = empty && if_valid_i && !flush_i;
`else
    assign bypass_active = 1'b0;
`endif

    assign if_ready_o = !full;
    assign full_o     = full;
    assign empty_o    = empty;
    assign count_o    = count_q;

    // Flush hides the head in the same cycle; invalid heads always read as NOP with PC 0.
    assign id_valid_o = !flush_i && (!empty || bypass_active);

    always_comb begin
        id_pc_o    = '0;
        id_instr_o = NOP_INSTR;
        if (id_valid_o) begin
            if (bypass_active) begin
                id_pc_o    = if_pc_i;
                id_instr_o = if_instr_i;
            end else begin
                id_pc_o    = pc_mem_q[rd_ptr_q];
                id_instr_o = instr_mem_q[rd_ptr_q];
            end
        end
    end

    assign push       = if_valid_i && !full && !flush_i;
    assign pop        = id_valid_o && id_ready_i;
    assign push_store = push && !(bypass_active && id_ready_i);
    assign pop_store  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_store) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_store)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_store, pop_store})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage keeps no reset; stale data is never visible because valid gates the outputs.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push_store) begin
            pc_mem_q[wr_ptr_q]    <= if_pc_i;
            instr_mem_q[wr_ptr_q] <= if_instr_i;
        end
    end

endmodule

// File: doc/if_id_fetch_queue.md
# if_id_fetch_queue

Parametrised successor to the single-entry IF/ID pipeline register. It is a DEPTH-entry instruction queue between the fetch (IF) and decode (ID) stages of the RISC-V core. It decouples PC/instruction production from decode stalls using a valid/ready handshake on both sides. A branch-redirect flush empties it in one cycle, and it presents a canonical NOP to ID whenever it is empty.

## Interface
Parameters:
- XLEN, 32, width of PC field.
- DEPTH, 4, number of entries; power of two, ≥ 2.
- NOP_INSTR, 32'h0000_0013, instruction driven on id_instr when no valid entry (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; low clears all state immediately.
- if_valid  input  1  IF offers an entry this cycle.
- if_pc  input  XLEN  PC of offered instruction.
- if_instr  input  32  offered instruction word.
- if_ready  output  1  queue accepts; equals !full, with no combinational dependence on id_ready.
- flush  input  1  branch redirect (PCSrc); discard all contents.
- id_valid  output  1  head entry is valid.
- id_pc  output  XLEN  PC of head entry.
- id_instr  output  32  head instruction; NOP_INSTR when id_valid=0.
- id_ready  input  1  ID consumes the head (IF_ID_write semantics).
- count  output  $clog2(DEPTH)+1  occupied entries.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.

## Operation
- Storage: circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus a count register.
- Push occurs when if_valid && if_ready && !flush. The entry is written at wr_ptr, and wr_ptr increments.
- Pop occurs when id_valid && id_ready && !flush, and rd_ptr increments.
- Simultaneous push and pop leave count unchanged; both pointers advance.
- Full: if_ready=0 and pushes are dropped, even when a pop occurs the same cycle.
- Empty: id_valid=0, id_pc=0, id_instr=NOP_INSTR, and id_ready is ignored.
- Flush has highest priority. On the next edge, pointers and count go to 0, and that cycle's push and pop are discarded. id_valid is forced to 0 combinationally during the flush cycle.
- The outputs id_pc and id_instr are read combinationally from the entry at rd_ptr.
- Reset (asynchronous, any time, including mid-operation) sets:
  - wr_ptr=0, rd_ptr=0, count=0
  - id_valid=0, id_pc=0, id_instr=NOP_INSTR
  - if_ready=1, full=0, empty=1
- Entry contents are not cleared on reset.
- While reset is low, no push or pop occurs.

## Timing
- Without bypass, an entry pushed at edge N appears on id_* after edge N (one-cycle latency). It is popped at the first edge where id_ready=1.
- Throughput is one push and one pop per cycle sustained.
- if_ready and full change only after a clock edge or a reset assertion.
- Reset deassertion is synchronous to clk by the system; the first push is accepted at the first rising edge with reset high.

## Configuration
- IF_ID_BYPASS_EN defined:
  - When the queue is empty, if_valid=1 and flush=0, the id_* outputs reflect the if_* inputs in the same cycle, and id_valid=1.
  - If id_ready=1 as well, the entry passes through without being stored; pointers and count stay unchanged.
  - Otherwise it is stored as a normal push.
- IF_ID_BYPASS_EN undefined: no combinational IF→ID path; the one-cycle latency above applies.

## Test plan
- Reset then fill: reset low 2 cycles, then push PCs 0x0, 0x4, 0x8, 0xC with id_ready=0.
  - After reset: count=0, id_instr=0x00000013, if_ready=1.
  - After 4 pushes: count=4, full=1, if_ready=0.
  - A 5th push is dropped.
- Drain order: from full, set id_ready=1 for 4 cycles.
  - id_pc sequence is 0x0, 0x4, 0x8, 0xC.
  - Afterwards empty=1 and id_instr=NOP.
- Streaming wrap: push and pop every cycle for 10 entries (PC 0x100 upward, step 4).
  - count stays at 1 without bypass, or 0 with bypass.
  - Pointers wrap with no lost or duplicated PC.
- Flush mid-stream: with count=3, assert flush together with if_valid=1 and id_ready=1.
  - id_valid=0 in that cycle.
  - Next cycle count=0, and the pushed PC never appears.
- Async reset mid-operation: with count=2, drop reset between clock edges.
  - count=0 and id_valid=0 immediately, before the next edge.
- Bypass (IF_ID_BYPASS_EN): empty queue, push PC 0x200 with id_ready=1.
  - id_pc=0x200 and id_valid=1 in the same cycle.
  - count stays 0.
